// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register addresses, field positions, exception codes
// and helpers that pack the architectural register images.
package cp0_regfile_pkg;

  localparam logic [4:0] CP0_ADDR_SR    = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC   = 5'd14;
  localparam logic [4:0] CP0_ADDR_PRID  = 5'd15;

  localparam int unsigned SR_IE        = 0;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_BD     = 31;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] r;
    r                  = '0;
    r[SR_IM_LO +: 6]   = im;
    r[SR_EXL]          = exl;
    r[SR_IE]           = ie;
    return r;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] r;
    r                    = '0;
    r[CAUSE_BD]          = bd;
    r[CAUSE_IP_LO +: 6]  = ip;
    r[CAUSE_EXC_LO +: 5] = exc;
    return r;
  endfunction

endpackage

// File: rtl/cp0_int_sync.sv
// Multi-flop synchroniser for asynchronous interrupt lines, async-low clear.
module cp0_int_sync #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the raw lines through STAGES flops; stage 0 samples the async input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_i;
      for (int unsigned i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: SR, Cause, EPC, PRId, interrupt masking and
// exception entry capture for the M stage.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE  = 32'h0000_4D31,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [4:0]  Addr,
  input  logic [31:0] Din,
  input  logic [31:0] PC_M,
  input  logic [4:0]  Exception_Code,
  input  logic        Clear_Exception_Level,
  input  logic        CP0_Write_Enabled,
  input  logic        Branch_Delay,
  input  logic [5:0]  HWInt,
  output logic [31:0] Dout,
  output logic [31:0] EPC_Out,
  output logic        Int_Req
);

  logic [5:0]  hw_s;
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic        irq, exc, take;

  cp0_int_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .async_i (HWInt),
    .sync_o  (hw_s)
  );

  // Exception entry takes the whole edge; mtc0 then eret apply only without it,
  // and eret is evaluated last so its EXL clear overrides a written EXL.
  always_comb begin
    irq   = (|(hw_s & im_q)) & ie_q & ~exl_q;
    exc   = (Exception_Code != 5'd0) & ~exl_q;
    take  = irq | exc;
    im_d  = im_q;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    ip_d  = hw_s;
    exc_d = exc_q;
    epc_d = epc_q;
    if (take) begin
      exl_d = 1'b1;
      exc_d = irq ? 5'(EXC_INT) : Exception_Code;
      bd_d  = Branch_Delay;
      epc_d = (PC_M & 32'hFFFF_FFFC) - (Branch_Delay ? 32'd4 : 32'd0);
    end else begin
      if (CP0_Write_Enabled) begin
        case (Addr)
          CP0_ADDR_SR: begin
            im_d  = Din[SR_IM_LO +: 6];
            exl_d = Din[SR_EXL];
            ie_d  = Din[SR_IE];
          end
          CP0_ADDR_EPC: epc_d = Din & 32'hFFFF_FFFC;
          default: ;
        endcase
      end
      if (Clear_Exception_Level) exl_d = 1'b0;
    end
  end

  // Architectural state registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      ip_q  <= '0;
      exc_q <= '0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      ip_q  <= ip_d;
      exc_q <= exc_d;
      epc_q <= epc_d;
    end
  end

  // Combinational read port showing pre-edge state.
  always_comb begin
    Dout = '0;
    case (Addr)
      CP0_ADDR_SR:    Dout = pack_sr(im_q, exl_q, ie_q);
      CP0_ADDR_CAUSE: Dout = pack_cause(bd_q, ip_q, exc_q);
      CP0_ADDR_EPC:   Dout = epc_q;
      CP0_ADDR_PRID:  Dout = PRID_VALUE;
      default:        Dout = '0;
    endcase
  end

  assign EPC_Out = epc_q;
  assign Int_Req = take;

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expectations are queued as stimulus is
// applied and compared when the outputs are sampled on the falling edge.
module tb_cp0_regfile;

  localparam logic [31:0] PRID = 32'h0000_4D31;
  localparam int unsigned SEL_DOUT = 0;
  localparam int unsigned SEL_EPC  = 1;
  localparam int unsigned SEL_IRQ  = 2;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic [4:0]  Addr = '0;
  logic [31:0] Din = '0;
  logic [31:0] PC_M = '0;
  logic [4:0]  Exception_Code = '0;
  logic        Clear_Exception_Level = 1'b0;
  logic        CP0_Write_Enabled = 1'b0;
  logic        Branch_Delay = 1'b0;
  logic [5:0]  HWInt = '0;
  logic [31:0] Dout;
  logic [31:0] EPC_Out;
  logic        Int_Req;

  cp0_regfile #(
    .PRID_VALUE  (PRID),
    .SYNC_STAGES (2)
  ) dut (
    .Clk                   (Clk),
    .Reset_n               (Reset_n),
    .Addr                  (Addr),
    .Din                   (Din),
    .PC_M                  (PC_M),
    .Exception_Code        (Exception_Code),
    .Clear_Exception_Level (Clear_Exception_Level),
    .CP0_Write_Enabled     (CP0_Write_Enabled),
    .Branch_Delay          (Branch_Delay),
    .HWInt                 (HWInt),
    .Dout                  (Dout),
    .EPC_Out               (EPC_Out),
    .Int_Req               (Int_Req)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic cp0_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int unsigned sel, input logic [4:0] a,
                         input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.sel  = sel;
    e.addr = a;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  task automatic exp_rd(input string tag, input logic [4:0] a, input logic [31:0] v);
    sb_push(tag, SEL_DOUT, a, v);
  endtask

  task automatic exp_epc(input string tag, input logic [31:0] v);
    sb_push(tag, SEL_EPC, 5'd0, v);
  endtask

  task automatic exp_irq(input string tag, input logic v);
    sb_push(tag, SEL_IRQ, 5'd0, {31'b0, v});
  endtask

  // Pop every queued expectation and compare against the live outputs.
  task automatic sb_drain();
    logic [4:0]  saved;
    logic [31:0] obs;
    exp_t        e;
    saved = Addr;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel == SEL_DOUT) Addr = e.addr;
      #1;
      case (e.sel)
        SEL_DOUT: obs = Dout;
        SEL_EPC:  obs = EPC_Out;
        default:  obs = {31'b0, Int_Req};
      endcase
      cp0_check(e.tag, obs, e.val);
    end
    Addr = saved;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle();
    CP0_Write_Enabled     = 1'b0;
    Clear_Exception_Level = 1'b0;
    Exception_Code        = '0;
    Branch_Delay          = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    Addr              = a;
    Din               = d;
    CP0_Write_Enabled = 1'b1;
  endtask

  initial begin
    // Reset asserted mid-cycle: outputs clear without a clock edge.
    #3 Reset_n = 1'b0;
    exp_rd("rst_sr", 5'd12, 32'h0);
    exp_rd("rst_cause", 5'd13, 32'h0);
    exp_rd("rst_epc_rd", 5'd14, 32'h0);
    exp_rd("rst_prid", 5'd15, PRID);
    exp_rd("rst_unlisted", 5'd5, 32'h0);
    exp_epc("rst_epc_out", 32'h0);
    exp_irq("rst_irq", 1'b0);
    sb_drain();
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();

    // Hardware interrupt through the synchroniser.
    mtc0(5'd12, 32'h0000_0401);
    tick(); idle();
    exp_rd("int_sr_wr", 5'd12, 32'h0000_0401);
    exp_irq("int_idle", 1'b0);
    sb_drain();
    HWInt = 6'b000001;
    PC_M  = 32'h0000_1003;
    exp_irq("int_edge0", 1'b0);
    sb_drain();
    tick();
    exp_irq("int_edge1", 1'b0);
    sb_drain();
    tick();
    exp_irq("int_edge2", 1'b1);
    exp_rd("int_ip_not_yet", 5'd13, 32'h0);
    sb_drain();
    tick();
    exp_rd("int_sr_exl", 5'd12, 32'h0000_0403);
    exp_rd("int_cause", 5'd13, 32'h0000_0400);
    exp_epc("int_epc", 32'h0000_1000);
    exp_irq("int_drop", 1'b0);
    sb_drain();

    // eret together with mtc0 SR: EXL clear wins.
    mtc0(5'd12, 32'h0000_0403);
    Clear_Exception_Level = 1'b1;
    exp_irq("eret_pre", 1'b0);
    sb_drain();
    tick(); idle();
    exp_rd("eret_sr", 5'd12, 32'h0000_0401);
    exp_irq("eret_irq_again", 1'b1);
    sb_drain();

    // irq pending with exception code and mtc0 EPC in the same cycle.
    Exception_Code = 5'd10;
    PC_M = 32'h0000_2008;
    mtc0(5'd14, 32'h0000_1234);
    exp_irq("simul_pre", 1'b1);
    sb_drain();
    tick(); idle();
    exp_epc("simul_epc", 32'h0000_2008);
    exp_rd("simul_epc_rd", 5'd14, 32'h0000_2008);
    exp_rd("simul_cause", 5'd13, 32'h0000_0400);
    exp_rd("simul_sr", 5'd12, 32'h0000_0403);
    exp_irq("simul_post", 1'b0);
    sb_drain();

    // Quiesce: mask interrupts, leave exception level, let IP drain.
    HWInt = '0;
    mtc0(5'd12, 32'h0000_0002);
    tick(); idle();
    exp_rd("quiet_sr", 5'd12, 32'h0000_0002);
    sb_drain();
    Clear_Exception_Level = 1'b1;
    tick(); idle();
    exp_rd("quiet_eret", 5'd12, 32'h0);
    sb_drain();
    tick(); tick(); tick();
    exp_rd("quiet_cause", 5'd13, 32'h0);
    sb_drain();

    // Exception in a delay slot, then a second one ignored while EXL=1.
    Exception_Code = 5'd12;
    Branch_Delay   = 1'b1;
    PC_M           = 32'h0000_3010;
    exp_irq("ds_pre", 1'b1);
    sb_drain();
    tick(); idle();
    exp_epc("ds_epc", 32'h0000_300C);
    exp_rd("ds_cause", 5'd13, 32'h8000_0030);
    exp_rd("ds_sr", 5'd12, 32'h0000_0002);
    exp_irq("ds_post", 1'b0);
    sb_drain();
    Exception_Code = 5'd5;
    PC_M           = 32'h0000_4000;
    exp_irq("nested_pre", 1'b0);
    sb_drain();
    tick(); idle();
    exp_epc("nested_epc", 32'h0000_300C);
    exp_rd("nested_cause", 5'd13, 32'h8000_0030);
    sb_drain();

    // Delay-slot PC wraps below zero.
    Clear_Exception_Level = 1'b1;
    tick(); idle();
    Exception_Code = 5'd4;
    Branch_Delay   = 1'b1;
    PC_M           = 32'h0;
    tick(); idle();
    exp_epc("wrap_epc", 32'hFFFF_FFFC);
    exp_rd("wrap_cause", 5'd13, 32'h8000_0010);
    exp_rd("wrap_sr", 5'd12, 32'h0000_0002);
    sb_drain();

    // Write masking: Cause read-only, EPC low bits dropped, no bypass.
    mtc0(5'd13, 32'hFFFF_FFFF);
    tick(); idle();
    exp_rd("mask_cause", 5'd13, 32'h8000_0010);
    sb_drain();
    mtc0(5'd14, 32'h0000_1237);
    exp_rd("mask_no_bypass", 5'd14, 32'hFFFF_FFFC);
    sb_drain();
    tick(); idle();
    exp_epc("mask_epc", 32'h0000_1234);
    exp_rd("mask_epc_rd", 5'd14, 32'h0000_1234);
    sb_drain();
    mtc0(5'd15, 32'h0);
    tick(); idle();
    exp_rd("mask_prid", 5'd15, PRID);
    sb_drain();

    // Reset during a pending exception entry discards it.
    Clear_Exception_Level = 1'b1;
    tick(); idle();
    Exception_Code = 5'd12;
    PC_M           = 32'h0000_5000;
    exp_irq("rstx_pre", 1'b1);
    sb_drain();
    Reset_n = 1'b0;
    tick();
    Exception_Code = '0;
    exp_rd("rstx_sr", 5'd12, 32'h0);
    exp_rd("rstx_cause", 5'd13, 32'h0);
    exp_epc("rstx_epc", 32'h0);
    exp_irq("rstx_irq", 1'b0);
    sb_drain();
    Reset_n = 1'b1;
    tick();
    exp_rd("rstx_prid", 5'd15, PRID);
    sb_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
